// File: rtl/logic_mux_pkg.sv
// Shared types and helpers for the logic_mux_pipe datapath.
package logic_mux_pkg;

    typedef enum logic [1:0] {
        MODE_SELECT  = 2'b00,
        MODE_AND_ALL = 2'b01,
        MODE_OR_ALL  = 2'b10,
        MODE_AOI     = 2'b11
    } mode_e;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/logic_mux_pipe_stage.sv
// One pipeline slot: valid bit plus data/channel payload, loaded when the slot frees up.
module pipe_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_chan,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    chan
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    chan_q, chan_d;

    // Payload only moves with a real word so an empty slot keeps its last value.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        if (load) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
                chan_d = in_chan;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign chan  = chan_q;

endmodule

// File: rtl/logic_mux_pipe.sv
// Select-or-reduce across CHANNELS words, then a STAGES-deep valid/ready pipeline.
module logic_mux_pipe
    import logic_mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned STAGES   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   mode,
    input  logic [chan_w(CHANNELS)-1:0]  sel,
    input  logic                         rr_en,
    output logic [WIDTH-1:0]             out_data,
    output logic [chan_w(CHANNELS)-1:0]  out_chan,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int unsigned CW    = chan_w(CHANNELS);
    localparam int unsigned PAIRS = CHANNELS / 2;

    logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    idx;
    logic             accept;
    logic [WIDTH-1:0] func_data;
    logic [CW-1:0]    func_chan;

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic [CW-1:0]     c [STAGES];

    always_comb idx = rr_en ? rr_ptr_q : sel;

    // Combine function evaluated on the words being offered this cycle.
    always_comb begin
        func_data = '0;
        func_chan = '0;
        case (mode_e'(mode))
            MODE_SELECT: begin
                func_chan = idx;
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    if (32'(idx) == k) func_data = in_data[k*WIDTH +: WIDTH];
                end
            end
            MODE_AND_ALL: begin
                func_data = '1;
                for (int unsigned k = 0; k < CHANNELS; k++) func_data &= in_data[k*WIDTH +: WIDTH];
            end
            MODE_OR_ALL: begin
                for (int unsigned k = 0; k < CHANNELS; k++) func_data |= in_data[k*WIDTH +: WIDTH];
            end
            MODE_AOI: begin
                for (int unsigned p = 0; p < PAIRS; p++) begin
                    func_data |= in_data[(2*p)*WIDTH +: WIDTH] & in_data[(2*p+1)*WIDTH +: WIDTH];
                end
                func_data = ~func_data;
            end
            default: ;
        endcase
    end

    // A slot can load when empty or when everything downstream of it moves.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) rdy[i] = !v[i] || rdy[i+1];
    end

    assign in_ready = rdy[0];
    assign accept   = in_valid && rdy[0];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && (mode_e'(mode) == MODE_SELECT) && rr_en) begin
            rr_ptr_d = (rr_ptr_q == CW'(CHANNELS - 1)) ? '0 : rr_ptr_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             st_valid;
        logic [WIDTH-1:0] st_data;
        logic [CW-1:0]    st_chan;

        if (g == 0) begin : g_head
            assign st_valid = in_valid;
            assign st_data  = func_data;
            assign st_chan  = func_chan;
        end else begin : g_body
            assign st_valid = v[g-1];
            assign st_data  = d[g-1];
            assign st_chan  = c[g-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH),
            .CW    (CW)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .load     (rdy[g]),
            .in_valid (st_valid),
            .in_data  (st_data),
            .in_chan  (st_chan),
            .valid    (v[g]),
            .data     (d[g]),
            .chan     (c[g])
        );
    end

    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];
    assign out_chan  = c[STAGES-1];

endmodule
